rice_encoder: RTL and testbench
===============================

// Module: rice_encoder
// PURPOSE
//  Rice/Golomb-power-of-2 encoder: the compressing counterpart of the telemetry Rice decoder (orplane path).
//  Per sample: q = sample>>k emitted as fundamental sequence (q zeros then '1'), then k LSBs, MSB-first.
//  Bits are packed MSB-first into 32-bit words streamed out with valid/ready; used to build decoder stimulus and as the TX path.
// PARAMETERS
//  SAMPLE_W  32  sample width in bits
//  WORD_W    32  packed output word width
//  QMAX      31  FS length limit; escape threshold (only with RICE_ESCAPE_EN)
// PORTS
//  clk        in   1         clock, rising edge
//  reset      in   1         synchronous, active-high
//  k          in   5         split parameter, sampled with in_data on accept (0..SAMPLE_W-1)
//  in_data    in   SAMPLE_W  sample to encode
//  in_valid   in   1         sample present
//  in_ready   out  1         encoder can accept a sample this cycle
//  flush      in   1         pulse: zero-pad and emit partial word
//  out_data   out  WORD_W    packed codeword bits, first bit in [WORD_W-1]
//  out_valid  out  1         out_data valid
//  out_ready  in   1         sink accepts out_data
//  busy       out  1         encoding, flushing, or packer holds bits
// BEHAVIOUR
//  - One clock (clk); reset synchronous active-high: out_data=0, out_valid=0, in_ready=0 in that cycle then 1, busy=0, packer count=0, state IDLE.
//  - Accept: in_valid&&in_ready; latches sample, k, q=sample>>k; in_ready=0 until last bit of that codeword enters the packer.
//  - FSM: IDLE -> FS_ZERO (q cycles, 1 zero/cycle; skipped if q=0) -> FS_STOP ('1') -> SPLIT (k cycles, bits k-1..0; skipped if k=0) -> IDLE.
//  - Throughput: 1 bit/cycle; codeword of q+1+k bits takes q+1+k unstalled cycles; next accept earliest cycle after last bit.
//  - Packer: shifts bit into word buffer, count 0..WORD_W-1; on bit WORD_W word moves to out register same edge, count->0.
//  - Output reg: out_valid held with out_data stable until out_ready; word transfer allowed if !out_valid or out_ready same cycle.
//  - Stall: if buffer full-pending and out reg occupied without out_ready, FSM holds its bit (no loss, no duplication).
//  - flush: accepted only in IDLE with no pending accept; if count>0, pad zeros to WORD_W, emit word, count->0; if count=0, no word.
//    flush and in_valid same cycle: flush wins, in_ready=0 that cycle. flush outside IDLE ignored (caller must wait !busy).
//  - busy = state!=IDLE || count!=0 || flushing; out_valid alone does not set busy.
//  - Reset mid-codeword: partial codeword and packed bits discarded, no word emitted.
// CONFIGURATION
//  RICE_ESCAPE_EN defined: if q>=QMAX emit QMAX zeros, '1', then SAMPLE_W raw sample bits MSB-first (state ESC_RAW replaces SPLIT);
//    q<QMAX unchanged. Max codeword QMAX+1+SAMPLE_W bits.
//  RICE_ESCAPE_EN undefined: no limit; q up to 2^SAMPLE_W-1 zeros emitted (q counter SAMPLE_W bits); ESC_RAW absent.
// STRUCTURE
//  rice_pkg: FSM state enum (IDLE, FS_ZERO, FS_STOP, SPLIT, ESC_RAW, FLUSH), WORD_W, K_W=5 constants.
//  Sub-module rice_bit_packer: bit_in/bit_valid/bit_ready, flush/flush_done, word output reg with valid/ready.
//  Top holds FSM, q/k/remainder counters, sample latch.
// TESTING
//  - k=2, in_data=13, then flush -> bits 000101, out_data=32'h1400_0000 once, busy low after.
//  - k=0, eight samples 3 -> each "0001"; exactly one word 32'h1111_1111, no flush needed, count returns to 0.
//  - Same as above with out_ready=0 for 20 cycles after first word: out_data held, in_ready stalls, no bit lost; second word correct.
//  - flush with count=0 and with in_valid=1 same cycle -> no word emitted; sample accepted the following cycle.
//  - RICE_ESCAPE_EN, k=0, in_data=40 -> 31 zeros,'1',32'h0000_0028: words 32'h0000_0001 then 32'h0000_0028.
//  - Assert reset during FS_ZERO of k=0, in_data=20 -> out_valid=0, busy=0 next cycle; fresh sample encodes as after power-up.

Source files
------------

// File: rtl/rice_pkg.sv
// Rice encoder shared constants and FSM state type.
// RICE_ESCAPE_EN adds the ESC_RAW state for escape-coded samples.
package rice_pkg;

  localparam int RICE_SAMPLE_W = 32;
  localparam int RICE_WORD_W   = 32;
  localparam int RICE_QMAX     = 31;
  localparam int K_W           = 5;

  typedef enum logic [2:0] {
    IDLE,
    FS_ZERO,
    FS_STOP,
    SPLIT,
`ifdef RICE_ESCAPE_EN
    ESC_RAW,
`endif
    FLUSH
  } rice_state_e;

endpackage

// File: rtl/rice_encoder_if.sv
// Sample-in / packed-word-out handshake bundle of the Rice encoder.
// master drives samples and takes words; slave is the encoder.
interface rice_encoder_if #(
  parameter int SAMPLE_W = rice_pkg::RICE_SAMPLE_W,
  parameter int WORD_W   = rice_pkg::RICE_WORD_W
);
  import rice_pkg::*;

  logic [K_W-1:0]      k;
  logic [SAMPLE_W-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic                flush;
  logic [WORD_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;
  logic                busy;

  modport master (
    output k, in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  k, in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, busy
  );

endinterface

// File: rtl/rice_bit_packer.sv
// MSB-first bit packer with a single registered output word.
// Holds the incoming bit while a finished word cannot be handed off.
module rice_bit_packer
  import rice_pkg::*;
#(
  parameter int WORD_W = RICE_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  input  logic              flush,
  output logic              flush_done,
  output logic              empty,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CW = $clog2(WORD_W);
  localparam logic [CW:0] WFULL = WORD_W[CW:0];

  logic [WORD_W-1:0] buf_q;
  logic [CW-1:0]     cnt;
  logic [CW:0]       pad;
  logic              out_free;
  logic              last;
  logic              take;
  logic              flush_word;

  assign out_free   = !out_valid || out_ready;
  assign last       = cnt == CW'(WORD_W - 1);
  assign bit_ready  = !last || out_free;
  assign take       = bit_valid && bit_ready;
  assign empty      = cnt == '0;
  assign flush_done = flush && (empty || out_free);
  assign flush_word = flush_done && !empty;
  assign pad        = WFULL - {1'b0, cnt};

  // Valid bits sit in the low cnt positions; stale bits above are shifted out.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q     <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_ready)
        out_valid <= 1'b0;
      if (take) begin
        buf_q <= {buf_q[WORD_W-2:0], bit_in};
        if (last) begin
          out_data  <= {buf_q[WORD_W-2:0], bit_in};
          out_valid <= 1'b1;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (flush_word) begin
        out_data  <= buf_q << pad;
        out_valid <= 1'b1;
        cnt       <= '0;
      end
    end
  end

endmodule

// File: rtl/rice_encoder.sv
// Rice/Golomb-power-of-2 encoder, one code bit per clock into the packer.
// RICE_ESCAPE_EN: q >= QMAX emits QMAX zeros, '1', then the raw sample.
module rice_encoder
  import rice_pkg::*;
#(
  parameter int SAMPLE_W = RICE_SAMPLE_W,
  parameter int WORD_W   = RICE_WORD_W
`ifdef RICE_ESCAPE_EN
  ,
  parameter int QMAX     = RICE_QMAX
`endif
) (
  input logic          clk,
  input logic          reset,
  rice_encoder_if.slave bus
);

  rice_state_e         st;
  rice_state_e         nxt;
  logic [SAMPLE_W-1:0] sample_q;
  logic [SAMPLE_W-1:0] qcnt;
  logic [SAMPLE_W-1:0] qin;
  logic [K_W-1:0]      k_q;
  logic [K_W-1:0]      rcnt;
  logic                take_in;
  logic                bit_in;
  logic                bit_valid;
  logic                bit_ready;
  logic                pk_flush;
  logic                flush_done;
  logic                pk_empty;
  logic                step;
`ifdef RICE_ESCAPE_EN
  logic                esc_q;
  logic                esc_in;

  assign esc_in = qin >= SAMPLE_W'(QMAX);
`endif

  assign qin          = bus.in_data >> bus.k;
  assign step         = bit_valid && bit_ready;
  assign bus.in_ready = st == IDLE && !bus.flush && !reset;
  assign bus.busy     = st != IDLE || !pk_empty;

  always_ff @(posedge clk) begin
    if (reset)
      st <= IDLE;
    else
      st <= nxt;
  end

  always_comb begin
    nxt       = st;
    take_in   = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    pk_flush  = 1'b0;
    unique case (st)
      IDLE: begin
        // An empty packer makes flush a no-op, but it still blocks accept.
        if (bus.flush) begin
          if (!pk_empty)
            nxt = FLUSH;
        end else if (bus.in_valid) begin
          take_in = 1'b1;
          nxt     = (qin != '0) ? FS_ZERO : FS_STOP;
        end
      end
      FS_ZERO: begin
        bit_valid = 1'b1;
        if (bit_ready && qcnt == SAMPLE_W'(1))
          nxt = FS_STOP;
      end
      FS_STOP: begin
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        if (bit_ready) begin
`ifdef RICE_ESCAPE_EN
          if (esc_q)
            nxt = ESC_RAW;
          else
`endif
            nxt = (k_q != '0) ? SPLIT : IDLE;
        end
      end
`ifdef RICE_ESCAPE_EN
      SPLIT, ESC_RAW: begin
`else
      SPLIT: begin
`endif
        bit_in    = sample_q[rcnt];
        bit_valid = 1'b1;
        if (bit_ready && rcnt == '0)
          nxt = IDLE;
      end
      FLUSH: begin
        pk_flush = 1'b1;
        if (flush_done)
          nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= '0;
      k_q      <= '0;
      qcnt     <= '0;
      rcnt     <= '0;
`ifdef RICE_ESCAPE_EN
      esc_q    <= 1'b0;
`endif
    end else if (take_in) begin
      sample_q <= bus.in_data;
      k_q      <= bus.k;
`ifdef RICE_ESCAPE_EN
      esc_q    <= esc_in;
      qcnt     <= esc_in ? SAMPLE_W'(QMAX) : qin;
`else
      qcnt     <= qin;
`endif
    end else if (step) begin
      unique case (st)
        FS_ZERO: qcnt <= qcnt - 1'b1;
`ifdef RICE_ESCAPE_EN
        FS_STOP: rcnt <= esc_q ? K_W'(SAMPLE_W - 1) : k_q - 1'b1;
`else
        FS_STOP: rcnt <= k_q - 1'b1;
`endif
        default: rcnt <= rcnt - 1'b1;
      endcase
    end
  end

  rice_bit_packer #(
    .WORD_W(WORD_W)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .flush     (pk_flush),
    .flush_done(flush_done),
    .empty     (pk_empty),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready)
  );

endmodule

// File: tb/tb_rice_encoder.sv
// Bench for rice_encoder: bit-queue reference model plus directed cases.
// Build with RICE_ESCAPE_EN to exercise the escape path expectations.
module tb_rice_encoder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  rice_encoder_if bus ();

  rice_encoder dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          n_tests;
  int          n_fail;
  bit          bq[$];
  logic [31:0] expw[$];
  logic [31:0] got[$];
  bit          held;
  logic [31:0] held_data;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endfunction

  function automatic void timeout(string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out, required completion", nm);
  endfunction

  function automatic void model_pack();
    while (bq.size() >= 32) begin
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < 32; i++)
        w = {w[30:0], bq.pop_front()};
      expw.push_back(w);
    end
  endfunction

  // Codeword = q zeros, '1', k remainder bits MSB-first.
  function automatic void model_sample(int kk, logic [31:0] d);
    longint unsigned q;
    q = longint'(d >> kk);
`ifdef RICE_ESCAPE_EN
    if (q >= 31) begin
      repeat (31) bq.push_back(1'b0);
      bq.push_back(1'b1);
      for (int i = 31; i >= 0; i--)
        bq.push_back(d[i]);
    end else
`endif
    begin
      for (longint unsigned i = 0; i < q; i++)
        bq.push_back(1'b0);
      bq.push_back(1'b1);
      for (int i = kk - 1; i >= 0; i--)
        bq.push_back(d[i]);
    end
    model_pack();
  endfunction

  function automatic void model_flush();
    if (bq.size() > 0) begin
      while (bq.size() % 32 != 0)
        bq.push_back(1'b0);
      model_pack();
    end
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      bq.delete();
      expw.delete();
      held = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (held)
          chk("hold", bus.out_data, held_data);
        if (bus.out_ready) begin
          got.push_back(bus.out_data);
          if (expw.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL word: got %h, required no word", bus.out_data);
          end else begin
            chk("word", bus.out_data, expw.pop_front());
          end
          held = 1'b0;
        end else begin
          held      = 1'b1;
          held_data = bus.out_data;
        end
      end else begin
        held = 1'b0;
      end
      if (bus.flush)
        model_flush();
      else if (bus.in_valid && bus.in_ready)
        model_sample(int'(bus.k), bus.in_data);
    end
  end

  task automatic send(input logic [4:0] kk, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus.k        = kk;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok)
      timeout("send");
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok)
      timeout("idle");
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!bus.busy && !bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok)
      timeout("drain");
  endtask

  task automatic do_flush();
    wait_idle();
    @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
  endtask

  task automatic check_words(input string nm, input int n,
                             input logic [31:0] e0, input logic [31:0] e1);
    logic [31:0] e[2];
    e[0] = e0;
    e[1] = e1;
    chk({nm, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < got.size())
        chk({nm, "_data"}, got[i], e[i]);
    got.delete();
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    held         = 1'b0;
    reset        = 1'b1;
    bus.k        = '0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.out_ready = 1'b1;

    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready1", 32'(bus.in_ready), 32'd1);

    // k=2, 13: 000 1 01 padded
    send(5'd2, 32'd13);
    do_flush();
    wait_drain();
    chk("t1_busy", 32'(bus.busy), 32'd0);
    check_words("t1", 1, 32'h1400_0000, 32'h0);

    // eight "0001" fill exactly one word
    repeat (8) send(5'd0, 32'd3);
    wait_drain();
    chk("t2_busy", 32'(bus.busy), 32'd0);
    check_words("t2", 1, 32'h1111_1111, 32'h0);

    // sink back-pressure long enough to stall the encoder
    bus.out_ready = 1'b0;
    fork
      repeat (16) send(5'd0, 32'd3);
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
          @(negedge clk);
          if (bus.out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen)
          timeout("t3_first_word");
        repeat (60) @(negedge clk);
        chk("t3_stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t3_stall_busy", 32'(bus.busy), 32'd1);
        chk("t3_stall_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check_words("t3", 2, 32'h1111_1111, 32'h1111_1111);

    // flush on an empty packer beats in_valid, sample taken next cycle
    wait_idle();
    @(posedge clk);
    #1;
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.k        = 5'd0;
    bus.in_data  = 32'd3;
    @(negedge clk);
    chk("t4_flush_blocks", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("t4_accept_next", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (7) send(5'd0, 32'd3);
    wait_drain();
    check_words("t4", 1, 32'h1111_1111, 32'h0);

    // long fundamental sequence
    send(5'd0, 32'd40);
`ifdef RICE_ESCAPE_EN
    wait_drain();
    check_words("t5", 2, 32'h0000_0001, 32'h0000_0028);
`else
    do_flush();
    wait_drain();
    check_words("t5", 2, 32'h0000_0000, 32'h0080_0000);
`endif

    // reset in the middle of the zero run
    send(5'd0, 32'd20);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    send(5'd2, 32'd13);
    do_flush();
    wait_drain();
    check_words("t6", 1, 32'h1400_0000, 32'h0);

    chk("model_empty", 32'(expw.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
